// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO feeding an 8N1 UART transmitter.
//
// Parameters
//   BAUD_DIV  clocks per serial bit (4..4095)
//   DEPTH     FIFO entries (power of 2, 2..16)
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     push wr_data into the FIFO (dropped while full)
//   wr_data   byte to transmit
//   full      FIFO holds DEPTH bytes
//   empty     FIFO holds no bytes
//   busy      a frame is on the line
//   tx_done   one-cycle pulse during the last clock of each stop bit
//   TX        serial line, idle high, driven from a flop
module uart_tx_buf #(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx_done,
    output logic       TX
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        XMIT
    } state_t;

    state_t      state, state_nxt;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;

    // shreg[0] is the line itself; ones are shifted in from the top so the
    // register is all ones once the stop bit is reached and while idle.
    logic [9:0]  shreg;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;

    logic        push, load, shift, baud_end;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign push     = wr_en && !full;
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign TX       = shreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        busy      = 1'b0;
        tx_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load      = 1'b1;
                    state_nxt = XMIT;
                end
            end
            XMIT: begin
                busy = 1'b1;
                if (baud_end) begin
                    if (bit_cnt == 4'd9) begin
                        tx_done = 1'b1;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage has no reset: clearing the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            shreg    <= {1'b1, mem[rd_ptr], 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (shift) begin
            shreg    <= {1'b1, shreg[9:1]};
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else if (state == XMIT) begin
            baud_cnt <= baud_end ? '0 : baud_cnt + 12'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: randomized and directed bench for uart_tx_buf.
// A queue-and-timeline model predicts every output each cycle; a line
// decoder and directed literal checks pin the model to hand-derived values.
module tb_uart_tx_buf;

    localparam int unsigned B = 16;
    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, tx_done, tx;

    logic       wr_en2 = 1'b0;
    logic [7:0] wr_data2 = 8'h00;
    logic       full2, empty2, busy2, tx_done2, tx2;

    int checks = 0;
    int errors = 0;

    uart_tx_buf #(.BAUD_DIV(B), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .busy(busy), .tx_done(tx_done), .TX(tx)
    );

    uart_tx_buf dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_data(wr_data2),
        .full(full2), .empty(empty2), .busy(busy2), .tx_done(tx_done2), .TX(tx2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the time index into the current frame.
    logic [7:0] m_q[$];
    bit         m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;

    initial forever begin
        int  n;
        bit  acc, done;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_act = 1'b0;
            m_t   = 0;
        end else begin
            n    = m_q.size();
            acc  = wr_en && (n < D);
            done = m_act && (m_t == 10 * B - 1);
            if ((!m_act || done) && n > 0) begin
                m_cur = m_q.pop_front();
                m_act = 1'b1;
                m_t   = 0;
            end else if (done) begin
                m_act = 1'b0;
            end else if (m_act) begin
                m_t++;
            end
            if (acc) m_q.push_back(wr_data);
        end
    end

    function automatic int exp_tx();
        int k;
        if (!m_act) return 1;
        k = m_t / B;
        if (k == 0) return 0;
        if (k == 9) return 1;
        return int'(m_cur[k-1]);
    endfunction

    initial forever begin
        @(negedge clk);
        check("tx",      int'(tx),      exp_tx());
        check("busy",    int'(busy),    int'(m_act));
        check("tx_done", int'(tx_done), int'(m_act && m_t == 10 * B - 1));
        check("empty",   int'(empty),   int'(m_q.size() == 0));
        check("full",    int'(full),    int'(m_q.size() == D));
    end

    // Line decoder: samples each bit mid-way and collects received bytes.
    logic [7:0] rx_q[$];
    bit         rx_on = 1'b0;
    int         rx_n = 0;
    logic [7:0] rx_b = 8'h00;

    initial forever begin
        int k;
        @(negedge clk);
        if (!rst_n) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on = 1'b1;
                rx_n  = 1;
            end
        end else begin
            rx_n++;
            if (rx_n % B == B / 2) begin
                k = rx_n / B;
                if (k == 0) begin
                    check("start_bit", int'(tx), 0);
                end else if (k <= 8) begin
                    rx_b[k-1] = tx;
                end else begin
                    check("stop_bit", int'(tx), 1);
                    rx_q.push_back(rx_b);
                    rx_on = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'($urandom);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int c = 0;
        while (!(empty && !busy) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(empty && !busy), 1);
    endtask

    task automatic wait_tx_low(input int maxc, input string name);
        int c = 0;
        while (tx != 1'b0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(tx), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc, dn, rate, sl, c;
        int dpos[$];
        int gaps;
        bit seen, in_start;
        logic [9:0] a5_bits;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_tx", int'(tx), 1);

        // Single byte 0xA5: bits 0,1,0,1,0,0,1,0,1,1 (index k = bit k)
        a5_bits = 10'b1101001010;
        push(8'hA5);
        check("a5_lat0_tx", int'(tx), 1);
        check("a5_lat0_empty", int'(empty), 0);
        @(negedge clk);
        check("a5_lat1_tx", int'(tx), 0);
        bc = 0; dc = 0; dn = 0;
        for (int n = 1; n <= 170; n++) begin
            if (busy) bc++;
            if (tx_done) begin
                dc++;
                dn = n;
            end
            if (n % B == B / 2 && n / B < 10) check("a5_bit", int'(tx), int'(a5_bits[n / B]));
            @(negedge clk);
        end
        check("a5_busy_clks", bc, 160);
        check("a5_done_at", dn, 160);
        check("a5_done_cnt", dc, 1);

        // Back-to-back frames
        rx_q.delete();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        gaps = 0; seen = 1'b0;
        for (int n = 0; n < 700 && dpos.size() < 3; n++) begin
            if (busy) seen = 1'b1;
            else if (seen) gaps++;
            if (tx_done) dpos.push_back(n);
            @(negedge clk);
        end
        check("b2b_pulses", dpos.size(), 3);
        if (dpos.size() == 3) begin
            check("b2b_gap01", dpos[1] - dpos[0], 160);
            check("b2b_gap12", dpos[2] - dpos[1], 160);
        end
        check("b2b_idle_clks", gaps, 0);
        check("b2b_end_busy", int'(busy), 0);
        check("b2b_end_empty", int'(empty), 1);
        check("b2b_rx_cnt", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("b2b_rx0", int'(rx_q[0]), 'h00);
            check("b2b_rx1", int'(rx_q[1]), 'hFF);
            check("b2b_rx2", int'(rx_q[2]), 'h55);
        end

        // Overflow, then a push on the pop edge while full
        rx_q.delete();
        push(8'h10);
        repeat (5) @(negedge clk);
        push(8'h11);
        push(8'h12);
        push(8'h13);
        check("ovf_not_full3", int'(full), 0);
        push(8'h14);
        check("ovf_full4", int'(full), 1);
        push(8'h15);
        check("ovf_full5", int'(full), 1);
        c = 0;
        while (!tx_done && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("ovf_done_seen", int'(tx_done), 1);
        check("ovf_full_at_pop", int'(full), 1);
        wr_en   = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        wr_en   = 1'b0;
        check("popfull_not_full", int'(full), 0);
        wait_idle(1000, "ovf_drain");
        check("ovf_rx_cnt", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check("ovf_rx_byte", int'(rx_q[i]), 'h10 + i);

        // Reset in the middle of a frame
        rx_q.delete();
        push(8'h3C);
        wait_tx_low(5, "rstmid_start");
        repeat (49) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_tx", int'(tx), 1);
        check("rstmid_empty", int'(empty), 1);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_done", int'(tx_done), 0);
        check("rstmid_full", int'(full), 0);
        dc = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_done) dc++;
        end
        check("rstmid_no_done", dc, 0);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid_idle_tx", int'(tx), 1);
        check("rstmid_rx_none", rx_q.size(), 0);
        push(8'h81);
        wait_idle(400, "rstmid_drain");
        check("rstmid_rx_cnt", rx_q.size(), 1);
        if (rx_q.size() == 1) check("rstmid_rx0", int'(rx_q[0]), 'h81);

        // Randomized traffic at varying push rates
        rate = 1;
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) begin
                case ((i / 500) % 3)
                    0:       rate = 1;
                    1:       rate = 8;
                    default: rate = 60;
                endcase
            end
            wr_en   = ($urandom_range(99) < rate);
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle(1200, "rand_drain");

        // Default BAUD_DIV instance: 0x0F
        wr_en2   = 1'b1;
        wr_data2 = 8'h0F;
        @(negedge clk);
        wr_en2 = 1'b0;
        c = 0;
        while (tx2 != 1'b0 && c < 5) begin
            @(negedge clk);
            c++;
        end
        check("def_start", int'(tx2), 0);
        sl = 0; dn = 0; in_start = 1'b1;
        for (int n = 1; n <= 26100; n++) begin
            if (in_start && tx2 == 1'b0) sl++;
            else in_start = 1'b0;
            if (tx_done2) dn = n;
            @(negedge clk);
        end
        check("def_start_len", sl, 2604);
        check("def_done_at", dn, 26040);
        check("def_busy_end", int'(busy2), 0);
        check("def_empty_end", int'(empty2), 1);
        check("def_full_end", int'(full2), 0);
        check("def_tx_end", int'(tx2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
